// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I load/store width codes, the FSM state encoding, and small
// helpers that classify alignment and build memory lane controls.
package lsu_pkg;

  // RV32I funct3 width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  // Undefined width codes are reported as misaligned so they never reach memory.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic result;
    case (funct3)
      F3_B, F3_BU: result = 1'b0;
      F3_H, F3_HU: result = offset[0];
      F3_W:        result = (offset != 2'b00);
      default:     result = 1'b1;
    endcase
    return result;
  endfunction

  // Byte-lane enables; only the low two funct3 bits encode access size.
  function automatic logic [3:0] lane_enable(input logic [2:0] funct3,
                                             input logic [1:0] offset);
    logic [3:0] result;
    case (funct3[1:0])
      2'b00:   result = 4'b0001 << offset;
      2'b01:   result = 4'b0011 << offset;
      2'b10:   result = 4'b1111;
      default: result = 4'b0000;
    endcase
    return result;
  endfunction

  // Replicate right-aligned store data across all lanes so the byte enables
  // alone pick the destination, independent of offset.
  function automatic logic [31:0] replicate_store(input logic [2:0]  funct3,
                                                  input logic [31:0] wdata);
    logic [31:0] result;
    case (funct3[1:0])
      2'b00:   result = {4{wdata[7:0]}};
      2'b01:   result = {2{wdata[15:0]}};
      default: result = wdata;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extraction: selects the addressed byte or halfword from a
// memory word and sign- or zero-extends it according to funct3.
// Ports:
//   word   - raw 32-bit memory word
//   offset - byte offset of the access within the word
//   funct3 - RV32I width code
//   result - right-aligned, extended load value (0 for undefined codes)
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_val = 8'h00;
    case (offset)
      2'b00:   byte_val = word[7:0];
      2'b01:   byte_val = word[15:8];
      2'b10:   byte_val = word[23:16];
      2'b11:   byte_val = word[31:24];
      default: byte_val = 8'h00;
    endcase
    if (offset[1]) begin
      half_val = word[31:16];
    end else begin
      half_val = word[15:0];
    end
  end

  // Apply sign or zero extension.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_B:    result = {{24{byte_val[7]}}, byte_val};
      F3_BU:   result = {24'h00_0000, byte_val};
      F3_H:    result = {{16{half_val[15]}}, half_val};
      F3_HU:   result = {16'h0000, half_val};
      F3_W:    result = word;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port word-addressed data memory.
// Each request runs IDLE -> ACCESS -> RESP -> IDLE; faulting requests skip
// ACCESS and never strobe memory.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   req_*               - pipeline request handshake and payload
//   resp_*              - one-cycle completion pulse with result and fault flags
//   mem_*               - memory address, data, strobes and byte enables;
//                         mem_dataout is updated by the memory on falling clk
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_range_err,
  output logic [31:0] mem_addy,
  output logic [31:0] mem_datain,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_selector,
  input  logic [31:0] mem_dataout
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  lsu_state_t  state;
  lsu_state_t  next_state;

  // Request fields still needed after accept. Address and store data are
  // held in lane-aligned form directly in mem_addy / mem_datain.
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [1:0]  offset_q;

  logic        accept;
  logic        misaligned;
  logic        range_err;
  logic        fault;
  logic [31:0] load_result;

  // Classify the incoming request; only meaningful when accept is high.
  always_comb begin
    accept     = req_valid && req_ready && (state == ST_IDLE);
    misaligned = is_misaligned(req_funct3, req_addr[1:0]);
    range_err  = ({2'b00, req_addr[31:2]} >= MEM_LIMIT);
    fault      = misaligned || range_err;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (fault) begin
            next_state = ST_RESP;
          end else begin
            next_state = ST_ACCESS;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ACCESS: next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .word   (mem_dataout),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  // Registered request capture, memory controls and response outputs.
  // Reset clears strobes asynchronously so an interrupted store never
  // reaches the memory's falling-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready         <= 1'b0;
      funct3_q          <= 3'b000;
      store_q           <= 1'b0;
      offset_q          <= 2'b00;
      mem_addy          <= 32'h0000_0000;
      mem_datain        <= 32'h0000_0000;
      mem_wen           <= 1'b0;
      mem_ren           <= 1'b0;
      mem_byte_selector <= 4'b0000;
      resp_valid        <= 1'b0;
      resp_rdata        <= 32'h0000_0000;
      resp_misaligned   <= 1'b0;
      resp_range_err    <= 1'b0;
    end else begin
      req_ready <= (next_state == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            funct3_q <= req_funct3;
            store_q  <= req_store;
            offset_q <= req_addr[1:0];
            if (fault) begin
              // Misalignment wins over range error.
              resp_valid      <= 1'b1;
              resp_rdata      <= 32'h0000_0000;
              resp_misaligned <= misaligned;
              resp_range_err  <= range_err && !misaligned;
            end else begin
              mem_addy          <= {2'b00, req_addr[31:2]};
              mem_datain        <= replicate_store(req_funct3, req_wdata);
              mem_wen           <= req_store;
              mem_ren           <= !req_store;
              mem_byte_selector <= lane_enable(req_funct3, req_addr[1:0]);
            end
          end
        end
        ST_ACCESS: begin
          mem_addy          <= 32'h0000_0000;
          mem_datain        <= 32'h0000_0000;
          mem_wen           <= 1'b0;
          mem_ren           <= 1'b0;
          mem_byte_selector <= 4'b0000;
          resp_valid        <= 1'b1;
          // mem_dataout was refreshed on the falling edge inside ACCESS.
          resp_rdata        <= store_q ? 32'h0000_0000 : load_result;
        end
        ST_RESP: begin
          resp_valid      <= 1'b0;
          resp_rdata      <= 32'h0000_0000;
          resp_misaligned <= 1'b0;
          resp_range_err  <= 1'b0;
        end
        default: begin
          mem_wen           <= 1'b0;
          mem_ren           <= 1'b0;
          mem_byte_selector <= 4'b0000;
          resp_valid        <= 1'b0;
          resp_rdata        <= 32'h0000_0000;
          resp_misaligned   <= 1'b0;
          resp_range_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// loads/stores compared against a byte-level reference memory model.
module tb_load_store_unit;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_range_err;
  logic [31:0] mem_addy;
  logic [31:0] mem_datain;
  logic        mem_wen;
  logic        mem_ren;
  logic [3:0]  mem_byte_selector;
  logic [31:0] mem_dataout = 32'h0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_store         (req_store),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_misaligned   (resp_misaligned),
    .resp_range_err    (resp_range_err),
    .mem_addy          (mem_addy),
    .mem_datain        (mem_datain),
    .mem_wen           (mem_wen),
    .mem_ren           (mem_ren),
    .mem_byte_selector (mem_byte_selector),
    .mem_dataout       (mem_dataout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] env_mem [MEM_WORDS];  // memory seen by the DUT
  logic [31:0] ref_mem [MEM_WORDS];  // expected memory contents

  int cyc = 0;
  int accept_q[$];
  int both_cnt = 0;
  int stray_cnt = 0;
  int resp_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Attached memory: writes and read data update on the falling edge.
  always @(negedge clk) begin
    if (mem_wen && mem_addy < MEM_WORDS) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_selector[b]) env_mem[mem_addy[9:0]][8*b +: 8] = mem_datain[8*b +: 8];
    end
    mem_dataout = (mem_addy < MEM_WORDS) ? env_mem[mem_addy[9:0]] : 32'h0;
  end

  // Cycle monitor: accepts, strobe overlap, stray outputs, responses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (req_valid && req_ready) accept_q.push_back(cyc);
    if (mem_wen && mem_ren) both_cnt++;
    if (!mem_wen && !mem_ren && mem_byte_selector != 4'b0000) stray_cnt++;
    if (!resp_valid && (resp_rdata != 32'h0 || resp_misaligned || resp_range_err)) stray_cnt++;
    if (resp_valid) resp_cnt++;
  end

  // Reference: behaviour from access size / offset arithmetic.
  function automatic void model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, output bit mis, output bit rng,
                                output bit [31:0] rd, output bit [3:0] sel, output bit [31:0] din);
    int size, off;
    bit [63:0] val, mask;
    size = 1 << f3[1:0];
    off  = int'(a % 32'd4);
    mis  = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((a % 32'(size)) != 0);
    rng  = !mis && ((a >> 2) >= MEM_WORDS);
    sel  = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) din[8*i +: 8] = wd[8*(i % size) +: 8];
    rd = 32'h0;
    if (!st && !mis && !rng) begin
      val  = 64'(ref_mem[a >> 2]) >> (8 * off);
      mask = (64'd1 << (8 * size)) - 64'd1;
      val  = val & mask;
      if (f3[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | ~mask;
      rd = val[31:0];
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input bit st, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, output bit [31:0] ord);
    bit mis, rng, flt, owen, oren, omis, orng;
    bit [31:0] erd, edin, oaddy, odin;
    bit [3:0] esel, osel;
    int lat, scyc;
    model(st, f3, a, wd, mis, rng, erd, esel, edin);
    flt = mis || rng;
    wait_ready();
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; scyc = 0; ord = 32'h0; omis = 0; orng = 0;
    owen = 0; oren = 0; osel = 0; oaddy = 0; odin = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_wen || mem_ren) begin
        scyc++;
        owen = mem_wen; oren = mem_ren; osel = mem_byte_selector;
        oaddy = mem_addy; odin = mem_datain;
      end
      if (resp_valid && lat == 0) begin
        lat = k; ord = resp_rdata; omis = resp_misaligned; orng = resp_range_err;
      end
    end
    check_eq("misaligned", 32'(omis), 32'(mis));
    check_eq("range_err", 32'(orng), 32'(rng));
    check_eq("rdata", ord, erd);
    check_eq("strobe_cycles", 32'(scyc), flt ? 32'd0 : 32'd1);
    check_eq("latency", 32'(lat), flt ? 32'd1 : 32'd2);
    if (!flt) begin
      check_eq("wen", 32'(owen), 32'(st));
      check_eq("ren", 32'(oren), 32'(!st));
      check_eq("addy", oaddy, a >> 2);
      check_eq("sel", 32'(osel), 32'(esel));
      if (st) begin
        check_eq("datain", odin, edin);
        for (int i = 0; i < 4; i++)
          if (esel[i]) ref_mem[a >> 2][8*i +: 8] = edin[8*i +: 8];
      end
    end
  endtask

  initial begin
    bit [31:0] rd, old;
    bit st;
    bit [2:0] f3;
    bit [31:0] a, word;
    int rc, n_acc;

    for (int i = 0; i < MEM_WORDS; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end

    // Reset state
    #1 rst = 1'b1;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
    check_eq("rst_sel", 32'(mem_byte_selector), 32'd0);
    check_eq("rst_addy", mem_addy, 32'd0);
    check_eq("rst_datain", mem_datain, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // SW 0x10, SB/LB/LBU 0x13, LH misaligned, LW out of range
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd);
    check_eq("lw_back", rd, 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, rd);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd);
    check_eq("lb_sext", rd, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd);
    check_eq("lbu_zext", rd, 32'h000000A5);
    do_req(1'b0, 3'b001, 32'h11, 32'h0, rd);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd);
    do_req(1'b0, 3'b001, 32'h1001, 32'h0, rd);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      st = 1'($urandom_range(0, 1));
      if (st && $urandom_range(0, 7) != 0) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom);
      word = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1020, 1030)) : 32'($urandom_range(0, 15));
      a = (word << 2) | 32'($urandom_range(0, 3));
      do_req(st, f3, a, $urandom, rd);
    end

    // Reset during a store's ACCESS cycle, before the falling edge
    old = ref_mem[5];
    wait_ready();
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h14; req_wdata = ~old;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_eq("pre_rst_wen", 32'(mem_wen), 32'd1);
    rc = resp_cnt;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_drop_wen", 32'(mem_wen), 32'd0);
    check_eq("rst_drop_sel", 32'(mem_byte_selector), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_no_resp", 32'(resp_cnt), 32'(rc));
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd);
    check_eq("rst_no_write", rd, old);

    // Back-to-back loads with req_valid held high
    wait_ready();
    accept_q.delete();
    rc = resp_cnt;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_acc = accept_q.size();
    check_eq("b2b_accepts", 32'(n_acc >= 4), 32'd1);
    for (int i = 1; i < n_acc; i++)
      check_eq("b2b_spacing", 32'(accept_q[i] - accept_q[i-1]), 32'd3);
    check_eq("b2b_resps", 32'(resp_cnt - rc), 32'(n_acc));

    check_eq("strobe_overlap", 32'(both_cnt), 32'd0);
    check_eq("stray_outputs", 32'(stray_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words the attached data memory implements.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req_valid  in  1  pipeline request present.
REQ-005 SHALL have ports: req_ready  out  1  unit idle, request accepted when both high at rising edge.
REQ-006 SHALL have ports: req_store  in  1  1=store, 0=load.
REQ-007 SHALL have ports: req_funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have ports: req_addr  in  32  byte address.
REQ-009 SHALL have ports: req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have ports: resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: resp_rdata  out  32  extended load result, 0 for stores and faults.
REQ-012 SHALL have ports: resp_misaligned  out  1  alignment fault, valid with resp_valid.
REQ-013 SHALL have ports: resp_range_err  out  1  word index >= MEM_WORDS, valid with resp_valid.
REQ-014 SHALL have ports: mem_addy  out  32  word index to memory (req_addr[31:2], zero-extended).
REQ-015 SHALL have ports: mem_datain  out  32  lane-aligned store data.
REQ-016 SHALL have ports: mem_wen, mem_ren  out  1 each  memory strobes, never both high.
REQ-017 SHALL have ports: mem_byte_selector  out  4  byte-lane enables, bit n = bits [8n+7:8n].
REQ-018 SHALL have ports: mem_dataout  in  32  memory read word, updated by memory on falling clk.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready high only in IDLE.
REQ-020 SHALL, on accept, register funct3, store flag, address, byte offset and wdata; further req_valid ignored until IDLE.
REQ-021 SHALL detect misalignment at accept: H/HU with addr[0]=1, W with addr[1:0]!=0, any other funct3 value treated as misaligned; misaligned goes IDLE -> RESP directly, no strobe.
REQ-022 SHALL detect range error at accept (addr[31:2] >= MEM_WORDS); goes IDLE -> RESP, no strobe, resp_rdata=0; misaligned takes priority when both apply and only resp_misaligned is set.
REQ-023 SHALL assert exactly one of mem_ren/mem_wen for exactly the one ACCESS cycle; mem_addy, mem_datain, mem_byte_selector stable throughout that cycle.
REQ-024 SHALL drive byte_selector: B = 0001 << offset, H = 0011 << offset, W = 1111; 0000 outside ACCESS.
REQ-025 SHALL replicate store data: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}, W -> wdata.
REQ-026 SHALL capture mem_dataout at the rising edge ending ACCESS (memory updated it on the intervening falling edge).
REQ-027 SHALL select byte/half by registered offset; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-028 SHALL assert resp_valid for exactly the RESP cycle; load latency accept-edge to resp_valid = 2 cycles, fault latency 1 cycle; max throughput one request per 3 cycles.
REQ-029 SHALL hold resp_rdata/flags stable only while resp_valid; 0 otherwise.

Reset
REQ-030 SHALL on rst, immediately and asynchronously: state IDLE, mem_wen=mem_ren=0, mem_byte_selector=0, mem_addy=0, mem_datain=0, resp_valid=0, resp_rdata=0, both flags 0, req_ready=0 while rst high.
REQ-031 SHALL, on rst mid-ACCESS, drop strobes before the next falling edge so no partial write occurs; the in-flight request is discarded with no response.

Structure
REQ-032 SHALL place funct3 width codes and FSM state encodings in shared package lsu_pkg.
REQ-033 SHALL use one combinational sub-module load_extend (word, offset, funct3 -> result); all else in top.

Verification
REQ-034 SHALL cover: SW addr 0x10 data 0xDEADBEEF -> one ACCESS cycle, wen=1, addy=4, sel=1111, datain=0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-035 SHALL cover: SB addr 0x13 data 0x000000A5, then LB 0x13 -> sel=1000, datain=0xA5A5A5A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
REQ-036 SHALL cover: LH addr 0x11 -> resp_misaligned=1, resp_valid 1 cycle after accept, no wen/ren ever high.
REQ-037 SHALL cover: LW addr 0x1000 (word 1024, MEM_WORDS=1024) -> resp_range_err=1, rdata=0, no strobe.
REQ-038 SHALL cover: rst asserted during SW ACCESS cycle before falling edge -> wen falls immediately, target word unchanged, no resp_valid.
REQ-039 SHALL cover: req_valid held high continuously with back-to-back loads -> accepts spaced exactly 3 cycles, mem_wen and mem_ren never simultaneously high.
